// File: rtl/proj_pkg.sv
// Shared project constants and types for the nucleotide datapath.
package proj_pkg;

    // Bits per nucleotide as consumed by the k-mer buffer.
    localparam int KMER_BUFFER_BITS = 2;

    // Serializer defaults: nucleotides per packed word and length-field width.
    localparam int NUC_WORD_NUCS    = 16;
    localparam int NUC_SEQ_LEN_BITS = 16;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_FETCH = 2'd1,
        SER_EMIT  = 2'd2
    } ser_state_e;

endpackage

// File: rtl/proj_nuc_serializer.sv
// Nucleotide serializer: unpacks WORD_NUCS-nucleotide words into a
// one-nucleotide-per-beat stream.
// - Each sequence is framed by a start_over pulse.
// - Each sequence is terminated by a seq_done pulse after exactly seq_len beats.
// Optional build macro PROJ_NUC_SER_MSB_FIRST_EN: nucleotide 0 is taken from
// the top DATA_BITS of the word instead of the bottom.
module proj_nuc_serializer
    import proj_pkg::*;
#(
    parameter int DATA_BITS = KMER_BUFFER_BITS,
    parameter int WORD_NUCS = NUC_WORD_NUCS,
    parameter int LEN_BITS  = NUC_SEQ_LEN_BITS,
    parameter int WORD_BITS = WORD_NUCS * DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 seq_start,
    input  logic [LEN_BITS-1:0]  seq_len,
    input  logic                 flush,
    input  logic [WORD_BITS-1:0] in_word,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_BITS-1:0] out_nuc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 start_over,
    output logic                 seq_done,
    output logic                 busy
);

    localparam int                IDX_W    = $clog2(WORD_NUCS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_NUCS - 1);
    localparam logic [LEN_BITS-1:0] REM_ONE = LEN_BITS'(1);

    // Selects nucleotide idx from a packed word according to the packing order.
    function automatic logic [DATA_BITS-1:0] nuc_at(input logic [WORD_BITS-1:0] word,
                                                    input logic [IDX_W-1:0]     idx);
`ifdef PROJ_NUC_SER_MSB_FIRST_EN
        nuc_at = word[WORD_BITS - 1 - int'(idx) * DATA_BITS -: DATA_BITS];
`else
        nuc_at = word[int'(idx) * DATA_BITS +: DATA_BITS];
`endif
    endfunction

    ser_state_e             state_q;
    logic [LEN_BITS-1:0]    remaining_q;
    logic [IDX_W-1:0]       nuc_idx_q;
    logic [WORD_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   out_nuc_q;
    logic                   out_valid_q;
    logic                   start_over_q;
    logic                   seq_done_q;

    logic                   beat_s;
    logic                   last_of_word_s;
    logic                   more_left_s;
    logic                   in_ready_s;
    logic [IDX_W-1:0]       nuc_idx_d;
    logic [DATA_BITS-1:0]   next_nuc_d;

    // Beat detection, next-slot lookahead and the word-accept handshake.
    always_comb begin
        beat_s         = out_valid_q & out_ready;
        last_of_word_s = (nuc_idx_q == LAST_IDX);
        more_left_s    = (remaining_q > REM_ONE);
        nuc_idx_d      = nuc_idx_q + IDX_W'(1);
        next_nuc_d     = nuc_at(shift_q, nuc_idx_d);
        in_ready_s     = 1'b0;
        if (flush) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_q)
                SER_FETCH: in_ready_s = 1'b1;
                // Reload only on the final beat of a word when more nucleotides are owed.
                SER_EMIT:  in_ready_s = beat_s & last_of_word_s & more_left_s;
                default:   in_ready_s = 1'b0;
            endcase
        end
    end

    // Sequencing FSM with registered stream outputs and framing pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SER_IDLE;
            remaining_q  <= '0;
            nuc_idx_q    <= '0;
            shift_q      <= '0;
            out_nuc_q    <= '0;
            out_valid_q  <= 1'b0;
            start_over_q <= 1'b0;
            seq_done_q   <= 1'b0;
        end else if (flush) begin
            state_q      <= SER_IDLE;
            remaining_q  <= '0;
            nuc_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            start_over_q <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            start_over_q <= 1'b0;
            seq_done_q   <= 1'b0;
            case (state_q)
                SER_IDLE: begin
                    if (seq_start) begin
                        if (seq_len != '0) begin
                            remaining_q  <= seq_len;
                            start_over_q <= 1'b1;
                            state_q      <= SER_FETCH;
                        end else begin
                            // Empty sequence: terminate without framing a start.
                            seq_done_q <= 1'b1;
                        end
                    end
                end
                SER_FETCH: begin
                    if (in_valid) begin
                        shift_q     <= in_word;
                        nuc_idx_q   <= '0;
                        out_nuc_q   <= nuc_at(in_word, IDX_W'(0));
                        out_valid_q <= 1'b1;
                        state_q     <= SER_EMIT;
                    end
                end
                SER_EMIT: begin
                    if (beat_s) begin
                        if (!more_left_s) begin
                            // Last nucleotide of the sequence; any tail of the word is dropped.
                            remaining_q <= '0;
                            seq_done_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            state_q     <= SER_IDLE;
                        end else begin
                            remaining_q <= remaining_q - REM_ONE;
                            if (!last_of_word_s) begin
                                nuc_idx_q <= nuc_idx_d;
                                out_nuc_q <= next_nuc_d;
                            end else if (in_valid) begin
                                shift_q   <= in_word;
                                nuc_idx_q <= '0;
                                out_nuc_q <= nuc_at(in_word, IDX_W'(0));
                            end else begin
                                out_valid_q <= 1'b0;
                                state_q     <= SER_FETCH;
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= SER_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign out_nuc    = out_nuc_q;
    assign out_valid  = out_valid_q;
    assign start_over = start_over_q;
    assign seq_done   = seq_done_q;
    assign busy       = (state_q != SER_IDLE);

endmodule
